bridge_fifo_ctrl: RTL and testbench

BRIDGE_FIFO_CTRL -- requirements
Module: bridge_fifo_ctrl

---
 rtl/bridge_fifo_ctrl.sv | 164 ++++++++++++++++
 tb/tb_bridge_fifo_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bridge_fifo_ctrl.sv
// I2C-receive to UART-transmit bridge controller.
// A one-byte holding register feeds an external FIFO; a small TX FSM pops
// bytes from that FIFO and hands them to a UART. FIFO port access is
// arbitrated so write and read strobes are never high together.
module bridge_fifo_ctrl #(
    parameter int DEPTH      = 16,
    parameter int TX_TIMEOUT = 255
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_rx_valid,
    input  logic [7:0]                 i_rx_data,
    output logic                       o_rx_ready,
    output logic                       o_fifo_wr_en,
    output logic [7:0]                 o_fifo_wr_data,
    output logic                       o_fifo_rd_en,
    input  logic [7:0]                 i_fifo_rd_data,
    output logic                       o_tx_start,
    output logic [7:0]                 o_tx_data,
    input  logic                       i_tx_busy,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_err_drop,
    output logic                       o_err_timeout,
    input  logic                       i_clr_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TX_TIMEOUT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [TW-1:0] TMO_C   = TW'(TX_TIMEOUT);

    typedef enum logic [2:0] {IDLE, POP, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_v_q, hold_v_d;
    logic [CW-1:0] count_q, count_d;
    logic          last_wr_q, last_wr_d;   // 1: last grant went to write
    logic          wr_en_q, wr_en_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          rd_en_q, rd_en_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          drop_q, drop_d;
    logic          tmo_q, tmo_d;

    logic accept, wr_req, rd_req, wr_gnt, rd_gnt, tmo_set;

    assign accept = i_rx_valid && !hold_v_q;
    assign wr_req = hold_v_q && (count_q < DEPTH_C);
    assign rd_req = (state_q == IDLE) && (count_q != '0) && !i_tx_busy;
    // On contention the side that lost last time wins; lone requests always win.
    assign wr_gnt = wr_req && (!rd_req || !last_wr_q);
    assign rd_gnt = rd_req && !wr_gnt;

    // Next-state: holding register, arbitration, count, TX FSM and error flags.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        hold_v_d   = hold_v_q;
        count_d    = count_q;
        last_wr_d  = last_wr_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        rd_en_d    = 1'b0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        tmo_cnt_d  = tmo_cnt_q;
        tmo_set    = 1'b0;

        if (accept) begin
            hold_d   = i_rx_data;
            hold_v_d = 1'b1;
        end
        if (wr_gnt) begin
            wr_en_d   = 1'b1;
            wr_data_d = hold_q;
            hold_v_d  = 1'b0;
            count_d   = count_q + CW'(1);
            last_wr_d = 1'b1;
        end
        if (rd_gnt) begin
            rd_en_d   = 1'b1;
            count_d   = count_q - CW'(1);
            last_wr_d = 1'b0;
        end

        case (state_q)
            IDLE:      if (rd_gnt) state_d = POP;
            POP:       state_d = LOAD;
            LOAD: begin
                tx_data_d  = i_fifo_rd_data;
                tx_start_d = 1'b1;
                tmo_cnt_d  = '0;
                state_d    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (i_tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_cnt_q == TMO_C) begin
                    tmo_set = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            WAIT_DONE: if (!i_tx_busy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        // Clear beats a same-cycle set.
        drop_d = i_clr_err ? 1'b0 : (drop_q || (i_rx_valid && hold_v_q));
        tmo_d  = i_clr_err ? 1'b0 : (tmo_q || tmo_set);
    end

    // State registers; reset abandons any held or in-flight byte.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            hold_v_q   <= 1'b0;
            count_q    <= '0;
            last_wr_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            rd_en_q    <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            tmo_cnt_q  <= '0;
            drop_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            hold_v_q   <= hold_v_d;
            count_q    <= count_d;
            last_wr_q  <= last_wr_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            rd_en_q    <= rd_en_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            tmo_cnt_q  <= tmo_cnt_d;
            drop_q     <= drop_d;
            tmo_q      <= tmo_d;
        end
    end

    assign o_rx_ready     = !hold_v_q;
    assign o_fifo_wr_en   = wr_en_q;
    assign o_fifo_wr_data = wr_data_q;
    assign o_fifo_rd_en   = rd_en_q;
    assign o_tx_start     = tx_start_q;
    assign o_tx_data      = tx_data_q;
    assign o_count        = count_q;
    assign o_full         = (count_q == DEPTH_C);
    assign o_empty        = (count_q == '0);
    assign o_err_drop     = drop_q;
    assign o_err_timeout  = tmo_q;

endmodule

// File: tb/tb_bridge_fifo_ctrl.sv
// Bench for bridge_fifo_ctrl: an attached-FIFO stand-in, a transaction-level
// reference model compared every cycle, directed scenarios with literal
// expectations, then randomized traffic with a mid-run reset.
module tb_bridge_fifo_ctrl;
    localparam int DEPTH = 16;
    localparam int TX_TIMEOUT = 255;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_rx_valid = 1'b0;
    logic [7:0] i_rx_data = '0;
    logic       o_rx_ready, o_fifo_wr_en, o_fifo_rd_en, o_tx_start;
    logic [7:0] o_fifo_wr_data, o_tx_data;
    logic [7:0] i_fifo_rd_data;
    logic       i_tx_busy = 1'b0;
    logic [4:0] o_count;
    logic       o_full, o_empty, o_err_drop, o_err_timeout;
    logic       i_clr_err = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    bridge_fifo_ctrl #(.DEPTH(DEPTH), .TX_TIMEOUT(TX_TIMEOUT)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .o_rx_ready(o_rx_ready),
        .o_fifo_wr_en(o_fifo_wr_en), .o_fifo_wr_data(o_fifo_wr_data),
        .o_fifo_rd_en(o_fifo_rd_en), .i_fifo_rd_data(i_fifo_rd_data),
        .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .i_tx_busy(i_tx_busy),
        .o_count(o_count), .o_full(o_full), .o_empty(o_empty),
        .o_err_drop(o_err_drop), .o_err_timeout(o_err_timeout), .i_clr_err(i_clr_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // Attached FIFO stand-in: data appears the cycle after the read strobe.
    logic [7:0] env_q[$];
    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            env_q.delete();
            i_fifo_rd_data <= '0;
        end else begin
            if (o_fifo_wr_en) env_q.push_back(o_fifo_wr_data);
            if (o_fifo_rd_en && env_q.size() > 0) i_fifo_rd_data <= env_q.pop_front();
        end
    end

    // Reference model: bytes in a queue, TX progress tracked by cycle numbers.
    logic [7:0] m_q[$];
    bit         m_hold_v = 0, m_last_wr = 0, m_wr_en = 0, m_rd_en = 0, m_tx_start = 0;
    bit         m_drop = 0, m_tmo = 0, m_active = 0, m_seen_busy = 0;
    logic [7:0] m_hold = 0, m_wr_data = 0, m_tx_data = 0, m_rd_byte = 0;
    int         m_count = 0, m_cyc = 0, m_start_cyc = 0;

    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            m_q.delete();
            m_hold_v = 0; m_last_wr = 0; m_wr_en = 0; m_rd_en = 0; m_tx_start = 0;
            m_drop = 0; m_tmo = 0; m_active = 0; m_seen_busy = 0;
            m_hold = 0; m_wr_data = 0; m_tx_data = 0; m_count = 0; m_cyc = 0;
        end else begin
            bit wreq, rreq, wg, rg, acc, start_next, tmo_hit;
            wreq = m_hold_v && (m_count < DEPTH);
            rreq = !m_active && (m_count > 0) && !i_tx_busy;
            wg   = wreq && (!rreq || !m_last_wr);
            rg   = rreq && !wg;
            acc  = i_rx_valid && !m_hold_v;
            start_next = 0;
            tmo_hit = 0;
            if (m_active) begin
                if (m_cyc + 1 == m_start_cyc) begin
                    start_next = 1;
                    m_tx_data = m_rd_byte;
                end
                if (m_cyc >= m_start_cyc) begin
                    if (!m_seen_busy) begin
                        if (i_tx_busy) m_seen_busy = 1;
                        else if (m_cyc - m_start_cyc == TX_TIMEOUT) begin
                            tmo_hit = 1;
                            m_active = 0;
                        end
                    end else if (!i_tx_busy) m_active = 0;
                end
            end
            if (rg) begin
                m_active = 1;
                m_seen_busy = 0;
                m_start_cyc = m_cyc + 3;
                m_rd_byte = m_q.pop_front();
                m_count--;
            end
            if (wg) begin
                m_q.push_back(m_hold);
                m_wr_data = m_hold;
                m_hold_v = 0;
                m_count++;
            end
            if (i_clr_err) begin
                m_drop = 0; m_tmo = 0;
            end else begin
                if (i_rx_valid && !acc) m_drop = 1;
                if (tmo_hit) m_tmo = 1;
            end
            if (acc) begin
                m_hold = i_rx_data;
                m_hold_v = 1;
            end
            if (wg || rg) m_last_wr = wg;
            m_wr_en = wg;
            m_rd_en = rg;
            m_tx_start = start_next;
            m_cyc++;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge i_clk) begin
        chk("rx_ready", o_rx_ready, !m_hold_v);
        chk("wr_en", o_fifo_wr_en, m_wr_en);
        if (m_wr_en) chk("wr_data", o_fifo_wr_data, m_wr_data);
        chk("rd_en", o_fifo_rd_en, m_rd_en);
        chk("strobe_excl", o_fifo_wr_en && o_fifo_rd_en, 0);
        chk("tx_start", o_tx_start, m_tx_start);
        chk("tx_data", o_tx_data, m_tx_data);
        chk("count", o_count, m_count);
        chk("full", o_full, m_count == DEPTH);
        chk("empty", o_empty, m_count == 0);
        chk("err_drop", o_err_drop, m_drop);
        chk("err_timeout", o_err_timeout, m_tmo);
    end

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic send(input logic [7:0] d);
        for (int k = 0; k < 50 && !o_rx_ready; k++) tick();
        chk("send_ready", o_rx_ready, 1);
        i_rx_valid = 1'b1;
        i_rx_data = d;
        tick();
        i_rx_valid = 1'b0;
    endtask

    task automatic wait_count(input int n);
        for (int k = 0; k < 100 && o_count != n; k++) tick();
        chk("wait_count", o_count, n);
    endtask

    task automatic pulse_reset();
        @(posedge i_clk);
        #2 i_reset_n = 1'b0;
        @(negedge i_clk);
        @(posedge i_clk);
        #2 i_reset_n = 1'b1;
        @(negedge i_clk);
    endtask

    int busy_left = 0;

    initial begin
        tick();
        chk("rst_rx_ready", o_rx_ready, 1);
        chk("rst_count", o_count, 0);
        chk("rst_empty", o_empty, 1);
        chk("rst_full", o_full, 0);
        i_reset_n = 1'b1;
        tick();

        // One byte end to end, then let the UART never go busy.
        i_rx_valid = 1'b1; i_rx_data = 8'hA5;
        tick();
        i_rx_valid = 1'b0;
        chk("a5_wr_wait", o_fifo_wr_en, 0);
        tick();
        chk("a5_wr_en", o_fifo_wr_en, 1);
        chk("a5_wr_data", o_fifo_wr_data, 8'hA5);
        chk("a5_count1", o_count, 1);
        tick();
        chk("a5_rd_en", o_fifo_rd_en, 1);
        chk("a5_count0", o_count, 0);
        tick();
        chk("a5_no_start", o_tx_start, 0);
        tick();
        chk("a5_tx_start", o_tx_start, 1);
        chk("a5_tx_data", o_tx_data, 8'hA5);
        repeat (255) tick();
        chk("tmo_not_yet", o_err_timeout, 0);
        tick();
        chk("tmo_set", o_err_timeout, 1);
        i_clr_err = 1'b1;
        tick();
        i_clr_err = 1'b0;
        chk("tmo_cleared", o_err_timeout, 0);

        // Fill with UART busy: 16 stored, 17th held, 18th dropped.
        i_tx_busy = 1'b1;
        for (int i = 0; i < 17; i++) send(8'(i + 1));
        tick(); tick();
        chk("fill_count", o_count, 16);
        chk("fill_full", o_full, 1);
        chk("fill_ready", o_rx_ready, 0);
        i_rx_valid = 1'b1; i_rx_data = 8'hEE;
        tick();
        i_rx_valid = 1'b0;
        chk("fill_drop", o_err_drop, 1);
        chk("fill_count2", o_count, 16);
        i_tx_busy = 1'b0;
        repeat (6) tick();
        pulse_reset();

        // Contention at count 3 after three writes: read wins, then write.
        i_tx_busy = 1'b1;
        for (int i = 0; i < 3; i++) send(8'h31 + 8'(i));
        wait_count(3);
        i_rx_valid = 1'b1; i_rx_data = 8'h34;
        tick();
        i_rx_valid = 1'b0;
        i_tx_busy = 1'b0;
        chk("cont_held", o_rx_ready, 0);
        tick();
        chk("cont_rd_first", o_fifo_rd_en, 1);
        chk("cont_count2", o_count, 2);
        tick();
        chk("cont_wr_second", o_fifo_wr_en, 1);
        chk("cont_count3", o_count, 3);
        i_tx_busy = 1'b1;
        tick();
        pulse_reset();

        // Reach WAIT_DONE with 5 stored, then reset between clock edges.
        i_tx_busy = 1'b1;
        for (int i = 0; i < 6; i++) send(8'h50 + 8'(i));
        wait_count(6);
        i_tx_busy = 1'b0;
        tick();
        i_tx_busy = 1'b1;
        chk("wd_rd_en", o_fifo_rd_en, 1);
        tick(); tick();
        chk("wd_tx_start", o_tx_start, 1);
        chk("wd_tx_data", o_tx_data, 8'h50);
        tick();
        chk("wd_count5", o_count, 5);
        @(posedge i_clk);
        #2 i_reset_n = 1'b0;
        #1;
        chk("ar_rx_ready", o_rx_ready, 1);
        chk("ar_wr_en", o_fifo_wr_en, 0);
        chk("ar_rd_en", o_fifo_rd_en, 0);
        chk("ar_tx_start", o_tx_start, 0);
        chk("ar_wr_data", o_fifo_wr_data, 0);
        chk("ar_tx_data", o_tx_data, 0);
        chk("ar_count", o_count, 0);
        chk("ar_empty", o_empty, 1);
        chk("ar_full", o_full, 0);
        chk("ar_drop", o_err_drop, 0);
        chk("ar_tmo", o_err_timeout, 0);
        @(negedge i_clk);
        i_tx_busy = 1'b0;
        @(posedge i_clk);
        #2 i_reset_n = 1'b1;
        @(negedge i_clk);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) pulse_reset();
            if (busy_left == 0) begin
                i_tx_busy = 1'($urandom % 2);
                busy_left = $urandom_range(1, 8);
            end
            busy_left--;
            i_rx_valid = (($urandom % 3) == 0);
            i_rx_data = 8'($urandom);
            i_clr_err = (($urandom % 40) == 0);
            tick();
        end
        i_rx_valid = 1'b0;
        i_clr_err = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
